chattering_multi: RTL and testbench

- Multi-channel debouncer for N mechanical inputs (buttons, switches). Each channel has an input synchroniser, a debounce counter with a run-time threshold, registered rise/fall pulses and a long-press pulse.
- Sits between board pins and control FSMs. Downstream logic consumes clean levels and single-cycle event strobes.

---
 rtl/chattering_multi_if.sv | 16 +
 rtl/chattering_multi.sv | 78 +++++++
 tb/tb_chattering_multi.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/chattering_multi_if.sv
// chattering_multi_if: raw inputs, shared threshold and debounced outputs of the multi-channel debouncer
// master: drives in/thresh, observes out/rise/fall/long_press
// slave : the debouncer side
interface chattering_multi_if #(
  parameter int N     = 4,
  parameter int CNT_W = 18
);
  logic [N-1:0]     in;
  logic [CNT_W-1:0] thresh;
  logic [N-1:0]     out;
  logic [N-1:0]     rise;
  logic [N-1:0]     fall;
  logic [N-1:0]     long_press;
  modport master (output in, thresh, input out, rise, fall, long_press);
  modport slave  (input in, thresh, output out, rise, fall, long_press);
endinterface

// File: rtl/chattering_multi.sv
// chattering_multi: N-channel debouncer with synchronisers, run-time threshold, rise/fall and long-press strobes
// clock : rising-edge system clock
// reset : asynchronous active-low reset
// bus   : slave side of chattering_multi_if (in, thresh -> out, rise, fall, long_press)
module chattering_multi #(
  parameter int N           = 4,
  parameter int CNT_W       = 18,
  parameter int SYNC_STAGES = 2,
  parameter int LONG_W      = 24,
  parameter int LONG_CYC    = 10000000
) (
  input logic              clock,
  input logic              reset,
  chattering_multi_if.slave bus
);
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (LONG_CYC < 0 || 64'(LONG_CYC) >= (64'd1 << LONG_W)) begin : g_bad_long
    $error("LONG_CYC must fit in LONG_W bits");
  end
  logic [N-1:0]     r_sync [SYNC_STAGES];
  logic [CNT_W-1:0] r_cnt [N];
  logic [N-1:0]     r_cand;
  logic [N-1:0]     r_out;
  logic [N-1:0]     r_rise;
  logic [N-1:0]     r_fall;
  logic [N-1:0]     w_s;
  logic [N-1:0]     w_out_nxt;
  assign w_s = r_sync[SYNC_STAGES-1];
  // out only takes cand once the candidate has been stable for thresh counted cycles
  always_comb begin
    w_out_nxt = r_out;
    for (int i = 0; i < N; i++)
      w_out_nxt[i] = (w_s[i] == r_cand[i] && r_cnt[i] >= bus.thresh) ? r_cand[i] : r_out[i];
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      for (int i = 0; i < N; i++) r_cnt[i] <= '0;
      r_cand <= '0;
      r_out  <= '0;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_sync[0] <= bus.in;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      for (int i = 0; i < N; i++)
        r_cnt[i] <= (w_s[i] != r_cand[i]) ? '0 : (r_cnt[i] < bus.thresh) ? r_cnt[i] + 1'b1 : r_cnt[i];
      r_cand <= w_s;
      r_out  <= w_out_nxt;
      r_rise <= w_out_nxt & ~r_out;
      r_fall <= ~w_out_nxt & r_out;
    end
  end
  assign bus.out  = r_out;
  assign bus.rise = r_rise;
  assign bus.fall = r_fall;
  if (LONG_CYC > 0) begin : g_long
    logic [LONG_W-1:0] r_lcnt [N];
    logic [N-1:0]      r_lp;
    // lcnt parks at LONG_CYC so the strobe fires once per press; gating with w_out_nxt keeps it off a fall edge
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < N; i++) r_lcnt[i] <= '0;
        r_lp <= '0;
      end else begin
        for (int i = 0; i < N; i++) begin
          r_lcnt[i] <= !r_out[i] ? '0 : (r_lcnt[i] == LONG_W'(LONG_CYC)) ? r_lcnt[i] : r_lcnt[i] + 1'b1;
          r_lp[i]   <= r_out[i] & w_out_nxt[i] & (r_lcnt[i] == LONG_W'(LONG_CYC - 1));
        end
      end
    end
    assign bus.long_press = r_lp;
  end else begin : g_no_long
    assign bus.long_press = '0;
  end
endmodule

// File: tb/tb_chattering_multi.sv
// tb_chattering_multi: directed and randomized checks of chattering_multi against a behavioural model
module tb_chattering_multi;
  localparam int N  = 4;
  localparam int CW = 4;
  localparam int SS = 2;
  localparam int LW = 8;
  localparam int LC = 20;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;
  chattering_multi_if #(.N(N), .CNT_W(CW)) bus ();
  chattering_multi #(.N(N), .CNT_W(CW), .SYNC_STAGES(SS), .LONG_W(LW), .LONG_CYC(LC)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );
  int checks = 0;
  int errors = 0;
  logic [N-1:0] hist [$];
  logic [N-1:0] m_cand, m_out, m_rise, m_fall, m_lp;
  int m_cnt [N];
  int m_since [N];
  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    hist.delete();
    repeat (SS) hist.push_back('0);
    m_cand = '0; m_out = '0; m_rise = '0; m_fall = '0; m_lp = '0;
    for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_since[i] = 0; end
  endtask
  task automatic model_edge(input logic [N-1:0] inv, input int th);
    logic [N-1:0] s;
    logic old;
    hist.push_back(inv);
    s = hist[hist.size() - 1 - SS];
    if (hist.size() > 16) void'(hist.pop_front());
    for (int i = 0; i < N; i++) begin
      old = m_out[i];
      if (s[i] != m_cand[i]) begin m_cand[i] = s[i]; m_cnt[i] = 0; end
      else if (m_cnt[i] < th) m_cnt[i]++;
      else m_out[i] = m_cand[i];
      m_rise[i] = !old && m_out[i];
      m_fall[i] = old && !m_out[i];
      if (m_rise[i]) m_since[i] = 0;
      else if (m_out[i] && m_since[i] <= LC) m_since[i]++;
      m_lp[i] = m_out[i] && !m_rise[i] && m_since[i] == LC;
    end
  endtask
  task automatic tick();
    @(posedge clock);
    if (!reset) model_reset();
    else model_edge(bus.in, int'(bus.thresh));
    #1;
    chk("out", bus.out, m_out);
    chk("rise", bus.rise, m_rise);
    chk("fall", bus.fall, m_fall);
    chk("long_press", bus.long_press, m_lp);
  endtask
  // kind 0 = rise, 1 = fall, 2 = long_press; reports -1 if the strobe never came
  task automatic wait_strobe(input string tag, input int ch, input int kind, input int exp);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 60) begin
      tick();
      n++;
      hit = kind == 0 ? bus.rise[ch] : kind == 1 ? bus.fall[ch] : bus.long_press[ch];
    end
    chki(tag, hit ? n : -1, exp);
  endtask
  initial begin
    int lp_seen;
    model_reset();
    bus.in = 4'hF;
    bus.thresh = 4'd5;
    reset = 1'b0;
    repeat (12) tick();
    bus.in = '0;
    reset = 1'b1;
    repeat (5) tick();
    bus.in[0] = 1'b1;
    wait_strobe("step_rise_lat", 0, 0, 9);
    tick();
    chki("step_rise_one_cycle", int'(bus.rise[0]), 0);
    bus.in[0] = 1'b0;
    wait_strobe("step_fall_lat", 0, 1, 9);
    bus.in = 4'b0101;
    repeat (12) tick();
    bus.in = 4'b1010;
    repeat (5) tick();
    #2 reset = 1'b0;
    #1;
    chk("async_rst_out", bus.out, '0);
    chk("async_rst_rise", bus.rise, '0);
    chk("async_rst_fall", bus.fall, '0);
    chk("async_rst_lp", bus.long_press, '0);
    model_reset();
    bus.in = '0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (4) tick();
    bus.in[1] = 1'b1; repeat (3) tick();
    bus.in[1] = 1'b0; repeat (3) tick();
    bus.in[1] = 1'b1; repeat (3) tick();
    bus.in[1] = 1'b0; repeat (3) tick();
    bus.in[1] = 1'b1;
    wait_strobe("bounce_rise_lat", 1, 0, 9);
    repeat (12) tick();
    bus.thresh = 4'd0;
    bus.in[0] = 1'b1;
    wait_strobe("thr0_rise_lat", 0, 0, 4);
    bus.thresh = 4'd15;
    bus.in[0] = 1'b0;
    wait_strobe("thr15_fall_lat", 0, 1, 19);
    bus.in[0] = 1'b1;
    repeat (13) tick();
    bus.thresh = 4'd2;
    tick();
    chki("thr_drop_rise", int'(bus.rise[0]), 1);
    bus.thresh = 4'd5;
    bus.in[2] = 1'b1;
    wait_strobe("lp_rise", 2, 0, 9);
    wait_strobe("lp_first", 2, 2, LC);
    lp_seen = 0;
    repeat (30) begin tick(); lp_seen += int'(bus.long_press[2]); end
    chki("lp_once_while_held", lp_seen, 0);
    bus.in[2] = 1'b0;
    wait_strobe("lp_release_fall", 2, 1, 9);
    repeat (3) tick();
    bus.in[2] = 1'b1;
    wait_strobe("lp_repress_rise", 2, 0, 9);
    wait_strobe("lp_second", 2, 2, LC);
    bus.in[2] = 1'b0;
    repeat (12) tick();
    bus.in[2] = 1'b1;
    wait_strobe("lp_short_rise", 2, 0, 9);
    repeat (6) tick();
    bus.in[2] = 1'b0;
    lp_seen = 0;
    repeat (30) begin tick(); lp_seen += int'(bus.long_press[2]); end
    chki("lp_short_none", lp_seen, 0);
    bus.in[0] = 1'b0;
    bus.in[3] = 1'b1;
    repeat (12) tick();
    bus.in[0] = 1'b1;
    bus.in[3] = 1'b0;
    wait_strobe("indep_rise0", 0, 0, 9);
    chki("indep_fall3", int'(bus.fall[3]), 1);
    chki("indep_ch1_held", int'(bus.out[1]), 1);
    for (int c = 0; c < 2000; c++) begin
      if (c % 200 == 0) bus.thresh = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) bus.in[i] = ~bus.in[i];
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
